// File: rtl/tape_capture_if.sv
// Tape-in and SDRAM write-port bundle for tape_capture.
// master = decoder side, slave = the environment feeding tape and acking writes.
interface tape_capture_if;
  logic        ce_sample;
  logic        tape_in;
  logic        start;
  logic        wr_req;
  logic        wr_ack;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        frame_err;
  logic        overrun;

  modport master (
    input  ce_sample, tape_in, start, wr_ack,
    output wr_req, addr, wdata, length, busy, done, frame_err, overrun
  );

  modport slave (
    output ce_sample, tape_in, start, wr_ack,
    input  wr_req, addr, wdata, length, busy, done, frame_err, overrun
  );
endinterface

// File: rtl/tape_capture.sv
// Aquarius cassette decoder: measures tape cycles between rising edges, frames
// 11-bit bytes (start 0, d7..d0, 1, 1) and writes each good byte to SDRAM.
module tape_capture #(
  parameter int SHORT_MIN = 8,
  parameter int SPLIT     = 24,
  parameter int LONG_MAX  = 48,
  parameter int GAP_LEN   = 256
) (
  input  logic clk,
  input  logic reset,
  tape_capture_if.master bus
);
  localparam int IDLE_W = $clog2(GAP_LEN + 1);
  localparam logic [7:0] SHORT_MIN_C = 8'(SHORT_MIN);
  localparam logic [7:0] SPLIT_C     = 8'(SPLIT);
  localparam logic [7:0] LONG_MAX_C  = 8'(LONG_MAX);
  localparam logic [7:0] CYC_SAT     = 8'(LONG_MAX + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(GAP_LEN);

  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_START2, S_BITS, S_STOP, S_DONE} state_t;
  typedef enum logic [1:0] {C_GLITCH, C_SHORT, C_LONG, C_GAP} cls_t;

  state_t state_q, state_d;
  cls_t   cls;
  logic   sync1_q, sync2_q, prev_q, prev_d;
  logic [7:0] cyc_q, cyc_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic   first_q, first_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic   phase_q, phase_d, pair_long_q, pair_long_d;
  logic [7:0] shift_q, shift_d, wdata_q, wdata_d;
  logic   commit_q, commit_d, wr_req_q, wr_req_d;
  logic [15:0] addr_q, addr_d, length_q, length_d;
  logic   frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic   rise;

  assign rise = bus.ce_sample && sync2_q && !prev_q;

  // The first edge after arming has no valid preceding cycle, so it counts as a gap.
  always_comb begin
    if (first_q)                  cls = C_GAP;
    else if (cyc_q < SHORT_MIN_C) cls = C_GLITCH;
    else if (cyc_q < SPLIT_C)     cls = C_SHORT;
    else if (cyc_q <= LONG_MAX_C) cls = C_LONG;
    else                          cls = C_GAP;
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = bus.ce_sample ? sync2_q : prev_q;
    cyc_d       = cyc_q;
    idle_d      = idle_q;
    first_d     = first_q && !rise;
    bit_cnt_d   = bit_cnt_q;
    phase_d     = phase_q;
    pair_long_d = pair_long_q;
    shift_d     = shift_q;
    commit_d    = 1'b0;
    wdata_d     = wdata_q;
    wr_req_d    = wr_req_q;
    addr_d      = addr_q;
    length_d    = length_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (rise) begin
      cyc_d  = 8'd0;
      idle_d = '0;
    end else if (bus.ce_sample) begin
      if (cyc_q < CYC_SAT) cyc_d = cyc_q + 8'd1;
      else if (idle_q < IDLE_MAX) idle_d = idle_q + 1'b1;
    end

    case (state_q)
      S_HUNT: begin
        if (rise && cls == C_LONG)
          state_d = S_START2;
        else if (idle_q >= IDLE_MAX && length_q != 16'd0 && !wr_req_q && !commit_q)
          state_d = S_DONE;
      end
      S_START2: begin
        if (rise) begin
          state_d   = (cls == C_LONG) ? S_BITS : S_HUNT;
          bit_cnt_d = 3'd0;
          phase_d   = 1'b0;
        end
      end
      S_BITS, S_STOP: begin
        if (rise) begin
          if (cls == C_GLITCH || cls == C_GAP) begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end else if (!phase_q) begin
            phase_d     = 1'b1;
            pair_long_d = (cls == C_LONG);
          end else begin
            phase_d = 1'b0;
            if ((cls == C_LONG) != pair_long_q || (state_q == S_STOP && pair_long_q)) begin
              frame_err_d = 1'b1;
              state_d     = S_HUNT;
            end else if (state_q == S_STOP) begin
              commit_d = 1'b1;
              state_d  = S_HUNT;
            end else begin
              shift_d   = {shift_q[6:0], !pair_long_q};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_d = S_STOP;
            end
          end
        end
      end
      default: ;
    endcase

    if (wr_req_q && bus.wr_ack) begin
      wr_req_d = 1'b0;
      if (addr_q == 16'hFFFF) begin
        length_d = 16'hFFFF;
        state_d  = S_DONE;
      end else begin
        addr_d   = addr_q + 16'd1;
        length_d = length_q + 16'd1;
      end
    end

    // A commit that finds the port still busy (even if acked this cycle) is dropped.
    if (commit_q) begin
      if (wr_req_q) begin
        overrun_d = 1'b1;
      end else begin
        wdata_d  = shift_q;
        wr_req_d = 1'b1;
      end
    end

    if (bus.start) begin
      state_d     = S_HUNT;
      first_d     = 1'b1;
      idle_d      = '0;
      phase_d     = 1'b0;
      commit_d    = 1'b0;
      wr_req_d    = 1'b0;
      addr_d      = 16'd0;
      length_d    = 16'd0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      cyc_q       <= 8'd0;
      idle_q      <= '0;
      first_q     <= 1'b1;
      bit_cnt_q   <= 3'd0;
      phase_q     <= 1'b0;
      pair_long_q <= 1'b0;
      shift_q     <= 8'd0;
      commit_q    <= 1'b0;
      wdata_q     <= 8'd0;
      wr_req_q    <= 1'b0;
      addr_q      <= 16'd0;
      length_q    <= 16'd0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.tape_in;
      sync2_q     <= sync1_q;
      prev_q      <= prev_d;
      cyc_q       <= cyc_d;
      idle_q      <= idle_d;
      first_q     <= first_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_q     <= phase_d;
      pair_long_q <= pair_long_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      wdata_q     <= wdata_d;
      wr_req_q    <= wr_req_d;
      addr_q      <= addr_d;
      length_q    <= length_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.wr_req    = wr_req_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.length    = length_q;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_tape_capture.sv
// Directed bench for tape_capture: synthesises short/long tape cycles and
// checks decoded writes, flags and end-of-tape against hand-derived values.
module tb_tape_capture;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  bit auto_ack = 1'b0;
  logic [15:0] wa[$];
  logic [7:0]  wd[$];

  tape_capture_if bus();

  tape_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Write responder: acks 2 clks after seeing wr_req and logs each accepted write.
  initial begin
    bus.wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && bus.wr_req) begin
        @(negedge clk);
        @(negedge clk);
        wa.push_back(bus.addr);
        wd.push_back(bus.wdata);
        $display("write addr=%h data=%h", bus.addr, bus.wdata);
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tcyc(input int hi, input int lo);
    bus.tape_in = 1'b1;
    repeat (hi) @(negedge clk);
    bus.tape_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic tshort(); tcyc(8, 8); endtask
  task automatic tlong();  tcyc(16, 16); endtask

  task automatic sbit(input logic b);
    if (b) begin tshort(); tshort(); end
    else   begin tlong();  tlong();  end
  endtask

  task automatic frame(input logic [7:0] v);
    sbit(1'b0);
    for (int i = 7; i >= 0; i--) sbit(v[i]);
    sbit(1'b1);
    sbit(1'b1);
  endtask

  task automatic leader(input int n);
    repeat (n) tshort();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.ce_sample = 1'b1;
    bus.tape_in   = 1'b0;
    bus.start     = 1'b0;
    idle(3);
    chk("rst_wr_req", 32'(bus.wr_req), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_length", 32'(bus.length), 32'd0);
    chk("rst_flags", {28'd0, bus.busy, bus.done, bus.frame_err, bus.overrun}, 32'd0);
    reset = 1'b0;
    idle(2);

    // 1: two good frames, then end of tape
    auto_ack = 1'b1;
    pulse_start();
    chk("t1_busy", 32'(bus.busy), 32'd1);
    leader(10);
    frame(8'h3A);
    frame(8'hC5);
    idle(400);
    $display("t1 writes=%0d length=%0d done=%b", wa.size(), bus.length, bus.done);
    chk("t1_nwrites", 32'(wa.size()), 32'd2);
    chk("t1_w0", {wa[0], 8'd0, wd[0]}, {16'h0000, 8'd0, 8'h3A});
    chk("t1_w1", {wa[1], 8'd0, wd[1]}, {16'h0001, 8'd0, 8'hC5});
    chk("t1_length", 32'(bus.length), 32'd2);
    chk("t1_done_busy_err", {29'd0, bus.done, bus.busy, bus.frame_err}, 32'b100);

    // 2: short+long pair in a data bit -> frame error, then a good frame
    wa.delete(); wd.delete();
    pulse_start();
    chk("t2_cleared", {bus.done, bus.frame_err, bus.length}, 32'd0);
    leader(6);
    sbit(1'b0);
    repeat (4) sbit(1'b1);
    tshort();
    tlong();
    leader(8);
    $display("t2 after bad pair frame_err=%b length=%0d", bus.frame_err, bus.length);
    chk("t2_err", 32'(bus.frame_err), 32'd1);
    chk("t2_nothing", {bus.wr_req, bus.length}, 32'd0);
    frame(8'h55);
    idle(40);
    $display("t2 writes=%0d", wa.size());
    chk("t2_nwrites", 32'(wa.size()), 32'd1);
    chk("t2_w0", {wa[0], 8'd0, wd[0]}, {16'h0000, 8'd0, 8'h55});
    chk("t2_length", 32'(bus.length), 32'd1);

    // 3: write held pending -> second byte overruns
    wa.delete(); wd.delete();
    auto_ack = 1'b0;
    pulse_start();
    leader(6);
    frame(8'hA1);
    frame(8'hB2);
    idle(20);
    $display("t3 pending wr_req=%b wdata=%h overrun=%b", bus.wr_req, bus.wdata, bus.overrun);
    chk("t3_pending", {bus.wr_req, bus.overrun, 6'd0, bus.wdata, bus.addr}, {1'b1, 1'b1, 6'd0, 8'hA1, 16'h0000});
    chk("t3_len0", 32'(bus.length), 32'd0);
    auto_ack = 1'b1;
    idle(10);
    $display("t3 after ack length=%0d writes=%0d", bus.length, wa.size());
    chk("t3_length", 32'(bus.length), 32'd1);
    chk("t3_w0", {wa[0], 8'd0, wd[0]}, {16'h0000, 8'd0, 8'hA1});
    chk("t3_req_clear", {bus.wr_req, bus.addr}, {1'b0, 16'h0001});
    idle(20);
    chk("t3_nwrites", 32'(wa.size()), 32'd1);

    // 4: glitch in leader ignored, glitch in data bits is an error
    wa.delete(); wd.delete();
    pulse_start();
    leader(4);
    tcyc(3, 3);
    leader(4);
    frame(8'h5A);
    idle(40);
    $display("t4 leader glitch writes=%0d frame_err=%b", wa.size(), bus.frame_err);
    chk("t4_ok_err", 32'(bus.frame_err), 32'd0);
    chk("t4_w0", {wa[0], 8'd0, wd[0]}, {16'h0000, 8'd0, 8'h5A});
    leader(4);
    sbit(1'b0);
    sbit(1'b1);
    tshort();
    tcyc(3, 3);
    leader(6);
    $display("t4 data glitch frame_err=%b length=%0d", bus.frame_err, bus.length);
    chk("t4_glitch_err", {bus.frame_err, bus.length}, {1'b1, 16'd1});

    // 5: memory full at the top address
    wa.delete(); wd.delete();
    pulse_start();
    force dut.addr_q = 16'hFFFE;
    idle(1);
    release dut.addr_q;
    idle(1);
    chk("t5_preload", 32'(bus.addr), 32'h0000FFFE);
    leader(4);
    frame(8'h11);
    idle(40);
    chk("t5_w0", {wa[0], 8'd0, wd[0]}, {16'hFFFE, 8'd0, 8'h11});
    chk("t5_addr1", {bus.addr, bus.done}, {16'hFFFF, 1'b0});
    frame(8'h22);
    idle(40);
    $display("t5 addr=%h length=%h done=%b busy=%b", bus.addr, bus.length, bus.done, bus.busy);
    chk("t5_w1", {wa[1], 8'd0, wd[1]}, {16'hFFFF, 8'd0, 8'h22});
    chk("t5_full", {bus.addr, bus.length}, 32'hFFFFFFFF);
    chk("t5_done", {bus.done, bus.busy, bus.wr_req}, 32'b100);

    // 6: reset and start while a write is pending mid-frame
    wa.delete(); wd.delete();
    auto_ack = 1'b0;
    pulse_start();
    leader(4);
    frame(8'h77);
    leader(2);
    sbit(1'b0);
    tshort();
    chk("t6_pending", 32'(bus.wr_req), 32'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    $display("t6 after reset wr_req=%b addr=%h busy=%b", bus.wr_req, bus.addr, bus.busy);
    chk("t6_rst_out", {bus.wr_req, bus.busy, bus.done, bus.frame_err, bus.overrun, 3'd0, bus.wdata, bus.addr},
        32'd0);
    chk("t6_rst_len", 32'(bus.length), 32'd0);
    pulse_start();
    leader(4);
    frame(8'h66);
    leader(1);
    sbit(1'b0);
    chk("t6_pending2", 32'(bus.wr_req), 32'd1);
    pulse_start();
    $display("t6 after start wr_req=%b addr=%h busy=%b", bus.wr_req, bus.addr, bus.busy);
    chk("t6_start", {bus.wr_req, bus.busy, bus.addr, 6'd0, bus.overrun, bus.frame_err}, {1'b0, 1'b1, 16'h0000, 8'd0});
    auto_ack = 1'b1;
    leader(6);
    frame(8'h99);
    idle(40);
    $display("t6 writes=%0d length=%0d", wa.size(), bus.length);
    chk("t6_nwrites", 32'(wa.size()), 32'd1);
    chk("t6_w0", {wa[0], 8'd0, wd[0]}, {16'h0000, 8'd0, 8'h99});
    chk("t6_final", {bus.length, 14'd0, bus.frame_err, bus.busy}, {16'd1, 14'd0, 1'b0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
